// File: rtl/display_sched_pkg.sv
// Shared types and helpers for the display scheduler: FSM state encoding,
// source-index width helper and a one-hot encoder (up to 8 sources).
package display_sched_pkg;

    localparam int MAX_SRC = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW   = 2'd1,
        MANUAL = 2'd2
    } state_t;

    function automatic int src_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_SRC-1:0] onehot(input logic [2:0] idx);
        logic [MAX_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/display_scheduler_rr_pick.sv
// Combinational round-robin picker: first set bit of req searching upward
// from start (inclusive), wrapping at N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [W-1:0] j;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(start) + k) % N);
            if (req[j]) begin
                idx   = j;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scheduler.sv
// Round-robin sharing of the seven-segment display among NUM_SRC requesters
// with switch override. Define DISP_PAGE_EN to show each value as two 16-bit pages.
module display_scheduler
    import display_sched_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int DATA_W      = 32,
    localparam int SRC_W      = src_w(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_SRC-1:0]        src_req,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_gnt,
    input  logic                      manual_en,
    input  logic [SRC_W-1:0]          manual_sel,
    output logic [DATA_W-1:0]         disp_data,
    output logic [SRC_W-1:0]          disp_src,
    output logic                      disp_valid
);

    localparam int CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
    localparam int HALF  = DATA_W / 2;

    state_t             state, state_n;
    logic [CNT_W-1:0]   hold_cnt, hold_n;
    logic [SRC_W-1:0]   last_ptr, ptr_n;
    logic [SRC_W-1:0]   idx_n;
    logic               valid_n;
    logic               advance;
    logic               expire;
    logic [SRC_W-1:0]   sel_eff;
    logic [SRC_W-1:0]   start;
    logic [SRC_W-1:0]   pick_idx;
    logic               pick_found;
    logic [DATA_W-1:0]  data_arr [NUM_SRC];
    logic [DATA_W-1:0]  data_sel;
    logic [DATA_W-1:0]  disp_n;
`ifdef DISP_PAGE_EN
    logic               page, page_n;
`endif

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign data_arr[i] = src_data[i*DATA_W +: DATA_W];
    end

    assign sel_eff = (int'(manual_sel) >= NUM_SRC) ? '0 : manual_sel;
    assign start   = (int'(last_ptr) == NUM_SRC - 1) ? '0 : last_ptr + 1'b1;
    assign expire  = (hold_cnt == CNT_W'(HOLD_CYCLES - 1));

    rr_pick #(.N(NUM_SRC), .W(SRC_W)) u_pick (
        .req   (src_req),
        .start (start),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        ptr_n   = last_ptr;
        idx_n   = disp_src;
        valid_n = disp_valid;
        advance = 1'b0;
`ifdef DISP_PAGE_EN
        page_n  = page;
`endif
        if (manual_en) begin
            state_n = MANUAL;
            idx_n   = sel_eff;
            ptr_n   = sel_eff;
            hold_n  = '0;
            valid_n = 1'b1;
`ifdef DISP_PAGE_EN
            page_n  = 1'b0;
`endif
        end else begin
            unique case (state)
                SHOW: begin
                    if (!src_req[disp_src]) begin
                        advance = 1'b1;
                    end else if (expire) begin
`ifdef DISP_PAGE_EN
                        if (!page) begin
                            page_n = 1'b1;
                            hold_n = '0;
                        end else begin
                            advance = 1'b1;
                        end
`else
                        advance = 1'b1;
`endif
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
                // IDLE, and MANUAL after the switch is released, both search afresh.
                default: advance = 1'b1;
            endcase

            if (advance) begin
                hold_n = '0;
`ifdef DISP_PAGE_EN
                page_n = 1'b0;
`endif
                if (pick_found) begin
                    state_n = SHOW;
                    idx_n   = pick_idx;
                    ptr_n   = pick_idx;
                    valid_n = 1'b1;
                end else begin
                    state_n = IDLE;
                    idx_n   = '0;
                    valid_n = 1'b0;
                end
            end
        end
    end

    assign data_sel = data_arr[idx_n];
`ifdef DISP_PAGE_EN
    assign disp_n = page_n ? DATA_W'(data_sel[DATA_W-1:HALF]) : DATA_W'(data_sel[HALF-1:0]);
`else
    assign disp_n = data_sel;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            last_ptr   <= SRC_W'(NUM_SRC - 1);
            src_gnt    <= '0;
            disp_src   <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
`ifdef DISP_PAGE_EN
            page       <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            hold_cnt   <= hold_n;
            last_ptr   <= ptr_n;
            src_gnt    <= valid_n ? NUM_SRC'(onehot(3'(idx_n))) : '0;
            disp_src   <= idx_n;
            disp_data  <= valid_n ? disp_n : '0;
            disp_valid <= valid_n;
`ifdef DISP_PAGE_EN
            page       <= page_n;
`endif
        end
    end

endmodule

// File: tb/tb_display_scheduler.sv
// Randomized bench for display_scheduler with an abstract reference model and
// a few hand-computed pinned expectations.
module tb_display_scheduler;

    localparam int N = 4;
    localparam int H = 4;
    localparam int W = 32;
`ifdef DISP_PAGE_EN
    localparam int NPAGE = 2;
`else
    localparam int NPAGE = 1;
`endif

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   src_req = '0;
    logic [N*W-1:0] src_data;
    logic           manual_en = 1'b0;
    logic [1:0]     manual_sel = '0;
    logic [N-1:0]   src_gnt;
    logic [W-1:0]   disp_data;
    logic [1:0]     disp_src;
    logic           disp_valid;

    always #5 clk = ~clk;

    display_scheduler #(.NUM_SRC(N), .HOLD_CYCLES(H), .DATA_W(W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .src_req    (src_req),
        .src_data   (src_data),
        .src_gnt    (src_gnt),
        .manual_en  (manual_en),
        .manual_sel (manual_sel),
        .disp_data  (disp_data),
        .disp_src   (disp_src),
        .disp_valid (disp_valid)
    );

    function automatic logic [W-1:0] shown(input logic [W-1:0] v, input int pg);
        if (NPAGE == 1) return v;
        return (pg != 0) ? {16'h0, v[31:16]} : {16'h0, v[15:0]};
    endfunction

    // Reference model: mode 0 = nothing shown, 1 = round-robin, 2 = manual.
    int           m_mode, m_cur, m_last, m_cnt, m_page;
    logic [N-1:0] e_gnt;
    logic [W-1:0] e_data;
    logic [1:0]   e_src;
    logic         e_valid;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = 0; m_cur = 0; m_last = N - 1; m_cnt = 0; m_page = 0;
        end else if (manual_en) begin
            m_mode = 2;
            m_cur  = (int'(manual_sel) >= N) ? 0 : int'(manual_sel);
            m_last = m_cur; m_cnt = 0; m_page = 0;
        end else begin
            bit adv, fnd;
            adv = 1'b0;
            if (m_mode != 1)                 adv = 1'b1;
            else if (!src_req[m_cur])        adv = 1'b1;
            else if (m_cnt == H - 1) begin
                if (m_page < NPAGE - 1) begin m_page++; m_cnt = 0; end
                else adv = 1'b1;
            end else m_cnt++;
            if (adv) begin
                fnd = 1'b0; m_cnt = 0; m_page = 0; m_mode = 0;
                for (int k = 1; k <= N; k++) begin
                    if (!fnd && src_req[(m_last + k) % N]) begin
                        fnd = 1'b1; m_cur = (m_last + k) % N;
                    end
                end
                if (fnd) begin m_mode = 1; m_last = m_cur; end
            end
        end
        e_valid = (m_mode != 0);
        e_gnt   = e_valid ? (N'(1) << m_cur) : '0;
        e_src   = e_valid ? m_cur[1:0] : 2'd0;
        e_data  = e_valid ? shown(src_data[m_cur*W +: W], m_page) : '0;
    end

    int           checks = 0;
    int           failures = 0;
    bit           chk_on = 1'b0;
    int           pin_seq = 0;
    int           pin_seen = 0;
    string        pin_nm;
    logic [N-1:0] pin_gnt;
    logic [W-1:0] pin_data;
    logic         pin_valid;
    bit           pin_flag_mode = 1'b0;
    bit           pin_flag;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("cyc_gnt",   W'(src_gnt),    W'(e_gnt));
            check("cyc_data",  disp_data,      e_data);
            check("cyc_src",   W'(disp_src),   W'(e_src));
            check("cyc_valid", W'(disp_valid), W'(e_valid));
        end
        if (pin_seq != pin_seen) begin
            pin_seen = pin_seq;
            if (pin_flag_mode) begin
                check(pin_nm, W'(pin_flag), W'(1));
            end else begin
                check({pin_nm, "_gnt"},   W'(src_gnt),    W'(pin_gnt));
                check({pin_nm, "_data"},  disp_data,      pin_data);
                check({pin_nm, "_valid"}, W'(disp_valid), W'(pin_valid));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pin(input string nm, input logic [N-1:0] g, input logic [W-1:0] d, input logic v);
        pin_nm = nm; pin_gnt = g; pin_data = d; pin_valid = v; pin_flag_mode = 1'b0;
        pin_seq++;
    endtask

    task automatic pin_flag_chk(input string nm, input bit f);
        pin_nm = nm; pin_flag = f; pin_flag_mode = 1'b1;
        pin_seq++;
    endtask

    initial begin
        int seq3[3];
        int e, slot, pg, j;
        bit found;
        seq3 = '{0, 1, 3};
        for (int i = 0; i < N; i++) src_data[i*W +: W] = 32'hA0A0_0000 + i;

        tick(); tick();
        chk_on = 1'b1;
        pin("reset", 4'b0000, 32'h0, 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        pin("idle", 4'b0000, 32'h0, 1'b0);

        // First grant one clock after the request.
        src_req = 4'b0001;
        tick();
        pin("t1", 4'b0001, shown(32'hA0A0_0000, 0), 1'b1);

        // Round-robin over 0,1,3 with no idle gap.
        src_req = 4'b1011;
        for (int i = 0; i < 15; i++) begin
            tick();
            e    = i + 2;
            slot = (e - 1) / (H * NPAGE);
            pg   = ((e - 1) % (H * NPAGE)) / H;
            pin("t2_rr", N'(1) << seq3[slot % 3],
                shown(32'hA0A0_0000 + seq3[slot % 3], pg), 1'b1);
        end

        // Drop source 1's request early while it is shown.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (src_gnt == 4'b0010) found = 1'b1;
        end
        pin_flag_chk("t3_wait_gnt1", found);
        tick();
        src_req = 4'b1001;
        tick();
        pin("t3_drop", 4'b1000, shown(32'hA0A0_0003, 0), 1'b1);
        src_req = 4'b0000;
        tick();
        pin("t3_idle", 4'b0000, 32'h0, 1'b0);

        // Manual override with no requests.
        manual_en = 1'b1; manual_sel = 2'd2;
        tick();
        pin("t4_manual", 4'b0100, shown(32'hA0A0_0002, 0), 1'b1);
        tick(); tick(); tick(); tick(); tick();
        pin("t4_hold", 4'b0100, shown(32'hA0A0_0002, 0), 1'b1);
        manual_en = 1'b0;
        tick();
        pin("t4_release", 4'b0000, 32'h0, 1'b0);

        // Reset mid-hold.
        src_req = 4'b1111;
        tick();
        pin("t5_grant", 4'b1000, shown(32'hA0A0_0003, 0), 1'b1);
        tick();
        reset_n = 1'b0;
        pin("t5_async", 4'b0000, 32'h0, 1'b0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        pin("t5_after", 4'b0001, shown(32'hA0A0_0000, 0), 1'b1);

`ifdef DISP_PAGE_EN
        src_data[31:0] = 32'h1234_5678;
        src_req = 4'b0011;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            pin("t6_page", 4'b0001, (i < 4) ? 32'h0000_5678 : 32'h0000_1234, 1'b1);
        end
        tick();
        pin("t6_next", 4'b0010, 32'h0000_0001, 1'b1);
`endif

        // Randomized traffic checked every cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            if (!reset_n) reset_n = 1'b1;
            else if ($urandom_range(0, 499) == 0) reset_n = 1'b0;
            if ($urandom_range(0, 7) == 0) src_req = N'($urandom);
            else if ($urandom_range(0, 3) == 0) begin
                j = $urandom_range(0, N - 1);
                src_req[j] = ~src_req[j];
            end
            if (manual_en) begin
                if ($urandom_range(0, 9) == 0) manual_en = 1'b0;
            end else if ($urandom_range(0, 59) == 0) manual_en = 1'b1;
            if ($urandom_range(0, 7) == 0) manual_sel = 2'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                j = $urandom_range(0, N - 1);
                src_data[j*W +: W] = $urandom;
            end
            tick();
        end

        tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
